im_rd_slave: RTL and testbench
==============================

Name: im_rd_slave

Overview:
AXI4 read-channel responder in front of the instruction SRAM. It is the memory end of the fetch path: it accepts read bursts from the CPU instruction master, drives word addresses to the 16 KW instruction SRAM, and returns data beats on the R channel. It is read-only, and write channels are not present. It sits between the AXI interconnect slave port and the SRAM macro.

Parameters:
IDW, 8, width of ARID/RID
AW, 32, AXI address width
DW, 32, data width (fixed to SRAM word)
SAW, 14, SRAM word-address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-low reset
arid  in  IDW  read ID
araddr  in  AW  byte address; word address = araddr[15:2]
arlen  in  4  beats minus one (0..15)
arsize  in  3  beat size
arburst  in  2  burst type
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  IDW  returned ID
rdata  out  DW  read data
rresp  out  2  response
rlast  out  1  final beat
rvalid  out  1  R valid
rready  in  1  R ready
sram_cs  out  1  SRAM chip select, active high
sram_oe  out  1  SRAM output enable, active high
sram_addr  out  SAW  SRAM word address
sram_rdata  in  DW  SRAM data, valid the cycle after sram_cs

Behaviour:
- Reset (rst=0, async): state=IDLE, arready=1, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, sram_cs=0, sram_oe=0, sram_addr=0, beat counter=0.
- FSM states: IDLE, REQ, CAP, RESP.
- IDLE: arready=1. On arvalid&&arready, latch arid, araddr[15:2], arlen, arburst, err flag, then go to REQ. Beat count=0.
- REQ: arready=0, sram_cs=1, sram_oe=1, sram_addr=current word address. Next state CAP.
- CAP: sram_oe=1, sram_cs=0. At the end of the cycle, rdata<=sram_rdata. Next state RESP.
- RESP: rvalid=1, rid=latched ID, rlast=(count==len), rresp=err?2'b10:2'b00. rdata/rid/rresp/rlast are stable while rvalid&&!rready.
  - On rready with rlast: go to IDLE, rvalid=0.
  - On rready without rlast: count+1, address update, go to REQ.
- Latency: AR handshake at edge N gives rvalid high in cycle N+3. With rready held at 1, each beat takes 3 cycles, and the next burst's AR is accepted in the cycle after the last beat.
- Address update: INCR (01) adds 1 modulo 2^14 (0x3FFF wraps to 0x0000). FIXED (00) holds the address. WRAP (10) and reserved (11) use INCR stepping and set err.
- err is also set when arsize!=3'b010. Data is still returned, and all beats of the burst carry SLVERR.
- araddr bits [1:0] and bits above 15 are ignored.
- No outstanding transactions: arready=0 from REQ until return to IDLE.
- Reset asserted mid-burst aborts immediately to the reset values. No partial beat or rlast is produced after release.
- arvalid deasserted before handshake: no effect, because arready is only sampled in IDLE.

Test Plan:
- Single beat: araddr=0x0000_0010, arlen=0, arsize=2, arburst=1, arid=0x5A, sram word 4=0xDEADBEEF, rready=1. Required: sram_addr=4 in cycle N+1; rvalid/rlast=1, rdata=0xDEADBEEF, rid=0x5A, rresp=0 in cycle N+3; arready=1 in cycle N+4.
- INCR burst with wrap: araddr=0x0000_FFF8, arlen=3. Required: sram_addr sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001; rlast only on the 4th beat.
- Backpressure: 2-beat burst with rready=0 for 5 cycles on beat 0. Required: rvalid stays 1, rdata/rid unchanged, no new sram_cs until rready=1. Then beat 1 is delivered 3 cycles later.
- FIXED and error: arburst=0, arlen=2, addr word 7. Required: three beats all from sram_addr=7, rresp=0. Repeat with arsize=1. Required: rresp=2'b10 on all beats, data still returned.
- Reset mid-burst: assert rst=0 during RESP of beat 1 of an 8-beat burst. Required: rvalid=0 and arready=1 immediately, no further sram_cs. A new single-beat read after release completes normally.
- Back-to-back: arvalid held high with two queued requests. Required: the second AR is accepted only after the first rlast handshake, and arready=0 during the burst.

Source files
------------

// File: rtl/im_rd_slave.sv
// AXI4 read-only responder for the instruction SRAM: one burst at a time, each beat is
// a three-cycle REQ/CAP/RESP sequence against a synchronous single-port SRAM.
module im_rd_slave #(
    parameter int unsigned IDW = 8,
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned SAW = 14
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [IDW-1:0] arid_i,
    input  logic [AW-1:0]  araddr_i,
    input  logic [3:0]     arlen_i,
    input  logic [2:0]     arsize_i,
    input  logic [1:0]     arburst_i,
    input  logic           arvalid_i,
    output logic           arready_o,
    output logic [IDW-1:0] rid_o,
    output logic [DW-1:0]  rdata_o,
    output logic [1:0]     rresp_o,
    output logic           rlast_o,
    output logic           rvalid_o,
    input  logic           rready_i,
    output logic           sram_cs_o,
    output logic           sram_oe_o,
    output logic [SAW-1:0] sram_addr_o,
    input  logic [DW-1:0]  sram_rdata_i
);

    typedef enum logic [1:0] {StIdle, StReq, StCap, StResp} state_e;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [2:0] SizeWord   = 3'b010;

    state_e         state_q, state_d;
    logic [IDW-1:0] id_q, id_d;
    logic [SAW-1:0] addr_q, addr_d;
    logic [3:0]     len_q, len_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [1:0]     burst_q, burst_d;
    logic           err_q, err_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic           last_beat;

    // Byte-lane bits and the region above the SRAM window are don't-care.
    logic unused_addr;
    assign unused_addr = ^{araddr_i[AW-1:SAW+2], araddr_i[1:0]};

    assign last_beat = (cnt_q == len_q);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (arvalid_i) begin
                    id_d    = arid_i;
                    addr_d  = araddr_i[SAW+1:2];
                    len_d   = arlen_i;
                    burst_d = arburst_i;
                    // WRAP and reserved bursts step like INCR but are flagged.
                    err_d   = (arsize_i != SizeWord) || arburst_i[1];
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: state_d = StCap;
            StCap: begin
                rdata_d = sram_rdata_i;
                state_d = StResp;
            end
            StResp: begin
                if (rready_i) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        addr_d  = (burst_q == BurstFixed) ? addr_q : addr_q + SAW'(1);
                        state_d = StReq;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign arready_o   = (state_q == StIdle);
    assign rvalid_o    = (state_q == StResp);
    assign rlast_o     = (state_q == StResp) && last_beat;
    assign rresp_o     = ((state_q == StResp) && err_q) ? 2'b10 : 2'b00;
    assign rid_o       = id_q;
    assign rdata_o     = rdata_q;
    assign sram_cs_o   = (state_q == StReq);
    assign sram_oe_o   = (state_q == StReq) || (state_q == StCap);
    assign sram_addr_o = addr_q;

endmodule

// File: tb/tb_im_rd_slave.sv
// Self-checking bench for im_rd_slave: directed scenarios plus random bursts checked
// beat-by-beat against a burst-level model over a behavioural SRAM.
module tb_im_rd_slave;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [3:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [7:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        sram_cs;
    logic        sram_oe;
    logic [13:0] sram_addr;
    logic [31:0] sram_rdata = '0;

    logic [31:0] mem [0:16383];
    int checks = 0;
    int errors = 0;

    im_rd_slave dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .arid_i      (arid),
        .araddr_i    (araddr),
        .arlen_i     (arlen),
        .arsize_i    (arsize),
        .arburst_i   (arburst),
        .arvalid_i   (arvalid),
        .arready_o   (arready),
        .rid_o       (rid),
        .rdata_o     (rdata),
        .rresp_o     (rresp),
        .rlast_o     (rlast),
        .rvalid_o    (rvalid),
        .rready_i    (rready),
        .sram_cs_o   (sram_cs),
        .sram_oe_o   (sram_oe),
        .sram_addr_o (sram_addr),
        .sram_rdata_i(sram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: data appears the cycle after chip select, garbage otherwise.
    always @(posedge clk) begin
        if (sram_cs) sram_rdata <= mem[sram_addr];
        else         sram_rdata <= $urandom;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] beat_addr(input req_t r, input int k);
        int w;
        w = int'(r.addr[15:2]);
        if (r.burst == 2'b00) return 14'(w);
        return 14'((w + k) % 16384);
    endfunction

    function automatic logic [1:0] exp_resp(input req_t r);
        return (r.size != 3'd2 || r.burst >= 2'd2) ? 2'b10 : 2'b00;
    endfunction

    task automatic drive_ar(input req_t r);
        arid    = r.id;
        araddr  = r.addr;
        arlen   = r.len;
        arsize  = r.size;
        arburst = r.burst;
        arvalid = 1'b1;
    endtask

    // pre: AR already driven and accepted-ready at the current negedge (chained request).
    // abort_beat >= 0: assert reset during RESP of that beat and return.
    task automatic run_burst(input req_t r, input int stall_beat, input int stall,
                             input bit chain, input req_t nxt, input bit pre,
                             input int abort_beat);
        logic [13:0] a;
        if (!pre) begin
            @(negedge clk);
            drive_ar(r);
            chk("ar_ready_idle", arready, 1);
        end
        @(posedge clk);
        #1;
        if (chain) drive_ar(nxt);
        else arvalid = 1'b0;
        for (int k = 0; k <= int'(r.len); k++) begin
            a = beat_addr(r, k);
            @(negedge clk);
            chk("req_cs", {sram_cs, sram_oe}, 2'b11);
            chk("req_addr", sram_addr, a);
            chk("req_busy", {arready, rvalid}, 2'b00);
            @(negedge clk);
            chk("cap_pins", {sram_cs, sram_oe, rvalid, arready}, 4'b0100);
            @(negedge clk);
            chk("resp_valid", {rvalid, sram_cs, arready}, 3'b100);
            chk("resp_data", rdata, mem[a]);
            chk("resp_id", rid, r.id);
            chk("resp_resp", rresp, exp_resp(r));
            chk("resp_last", rlast, k == int'(r.len));
            if (k == abort_beat) begin
                rst_n = 1'b0;
                #1;
                chk("abort_pins", {rvalid, rlast, arready, sram_cs, sram_oe}, 5'b00100);
                chk("abort_data", {rid, rdata}, 40'h0);
                return;
            end
            if (k == stall_beat && stall > 0) begin
                rready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    chk("stall_hold", {rvalid, sram_cs, arready}, 3'b100);
                    chk("stall_data", {rid, rdata}, {r.id, mem[a]});
                end
                rready = 1'b1;
            end
        end
        @(negedge clk);
        chk("post_idle", {arready, rvalid, rlast}, 3'b100);
    endtask

    initial begin
        req_t r, r2, none;
        none = '0;
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[4] = 32'hDEAD_BEEF;

        #1;
        chk("rst_ready", {arready, rvalid, rlast, sram_cs, sram_oe}, 5'b10000);
        chk("rst_vals", {rid, rdata, rresp, sram_addr}, 56'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single beat from word 4.
        r = '{id: 8'h5A, addr: 32'h0000_0010, len: 4'd0, size: 3'd2, burst: 2'd1};
        run_burst(r, -1, 0, 1'b0, none, 1'b0, -1);

        // INCR crossing the top of the SRAM.
        r = '{id: 8'h11, addr: 32'h0000_FFF8, len: 4'd3, size: 3'd2, burst: 2'd1};
        run_burst(r, -1, 0, 1'b0, none, 1'b0, -1);

        // Backpressure on beat 0.
        r = '{id: 8'h22, addr: 32'h0000_0100, len: 4'd1, size: 3'd2, burst: 2'd1};
        run_burst(r, 0, 5, 1'b0, none, 1'b0, -1);

        // FIXED, then the same with a bad size.
        r = '{id: 8'h33, addr: 32'h0000_001C, len: 4'd2, size: 3'd2, burst: 2'd0};
        run_burst(r, -1, 0, 1'b0, none, 1'b0, -1);
        r.size = 3'd1;
        run_burst(r, -1, 0, 1'b0, none, 1'b0, -1);

        // WRAP flagged but stepped like INCR; high address bits ignored.
        r = '{id: 8'h44, addr: 32'hABCD_7FFB, len: 4'd2, size: 3'd2, burst: 2'd2};
        run_burst(r, -1, 0, 1'b0, none, 1'b0, -1);

        // Reset during beat 1 of an 8-beat burst.
        r = '{id: 8'h66, addr: 32'h0000_0200, len: 4'd7, size: 3'd2, burst: 2'd1};
        run_burst(r, -1, 0, 1'b0, none, 1'b0, 1);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold", {sram_cs, rvalid, arready}, 3'b001);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {sram_cs, rvalid, arready}, 3'b001);
        r = '{id: 8'h77, addr: 32'h0000_0010, len: 4'd0, size: 3'd2, burst: 2'd1};
        run_burst(r, -1, 0, 1'b0, none, 1'b0, -1);

        // Back-to-back with arvalid held high across the first burst.
        r  = '{id: 8'h81, addr: 32'h0000_0400, len: 4'd2, size: 3'd2, burst: 2'd1};
        r2 = '{id: 8'h82, addr: 32'h0000_0800, len: 4'd1, size: 3'd2, burst: 2'd1};
        run_burst(r, -1, 0, 1'b1, r2, 1'b0, -1);
        run_burst(r2, -1, 0, 1'b0, none, 1'b1, -1);

        // Random bursts.
        for (int n = 0; n < 16; n++) begin
            r.id    = 8'($urandom);
            r.addr  = $urandom;
            r.len   = 4'($urandom_range(0, 15));
            r.size  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd2;
            r.burst = 2'($urandom);
            run_burst(r, $urandom_range(0, int'(r.len)), $urandom_range(0, 3),
                      1'b0, none, 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
